// File: rtl/peri_bus_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters one at a time onto a single peripheral bus.
// Latency: strobe one cycle after the request is seen in IDLE; completion L+2 cycles issue-to-issue.
// Backpressure: requests are held until the matching o_req_ready pulse; bus stalls are bounded by TIMEOUT.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_req_rden/wren/addr/wdata/wstrb per-requester command (slice i at [W*i +: W])
//   o_req_gnt, o_req_ready          one-hot single-cycle pulses: accepted / complete
//   o_req_rdata                     read data, valid while any o_req_ready bit is high
//   o_bus_rden/wren                 single-cycle command strobes to the peripheral bus
//   o_bus_addr/wdata/wstrb          command fields, stable for the whole transaction
//   i_bus_ready, i_bus_rdata        bus completion and its read data
//   o_timeout_err, o_err_id         forced-completion pulse and sticky offending requester index
module peri_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req_rden,
    input  logic [NUM_REQ-1:0]      i_req_wren,
    input  logic [NUM_REQ*32-1:0]   i_req_addr,
    input  logic [NUM_REQ*32-1:0]   i_req_wdata,
    input  logic [NUM_REQ*4-1:0]    i_req_wstrb,
    output logic [NUM_REQ-1:0]      o_req_gnt,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic [31:0]             o_req_rdata,
    output logic                    o_bus_rden,
    output logic                    o_bus_wren,
    output logic [31:0]             o_bus_addr,
    output logic [31:0]             o_bus_wdata,
    output logic [3:0]              o_bus_wstrb,
    input  logic                    i_bus_ready,
    input  logic [31:0]             i_bus_rdata,
    output logic                    o_timeout_err,
    output logic [2:0]              o_err_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [15:0]        CNT_LAST  = 16'(TIMEOUT - 1);
    localparam logic [2:0]         LAST_INIT = 3'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] REQ_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    // Index of the most recent grant; doubles as the owner of the in-flight transaction.
    logic [2:0]         last_winner;
    logic [15:0]        wait_cnt;
    logic [NUM_REQ-1:0] req_act;
    logic               win_vld;
    logic [2:0]         win_idx;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_wdata;
    logic [3:0]         sel_wstrb;
    logic               sel_rden;
    logic               sel_wren;
    logic               tmo_hit;

    assign req_act = i_req_rden | i_req_wren;
    assign tmo_hit = (wait_cnt == CNT_LAST);

    // Circular search starting just after the last winner: distance k=1 is the
    // highest priority, k=NUM_REQ (the last winner itself) the lowest.
    always_comb begin : pick_winner
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_vld && req_act[i] &&
                    ((int'(last_winner) + k == i) || (int'(last_winner) + k == i + NUM_REQ))) begin
                    win_vld = 1'b1;
                    win_idx = 3'(i);
                end
            end
        end
    end

    always_comb begin : sel_fields
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        sel_rden  = 1'b0;
        sel_wren  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == 3'(i)) begin
                sel_addr  = i_req_addr[32*i +: 32];
                sel_wdata = i_req_wdata[32*i +: 32];
                sel_wstrb = i_req_wstrb[4*i +: 4];
                sel_rden  = i_req_rden[i];
                sel_wren  = i_req_wren[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : state_reg
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin : next_state
        state_nxt = state;
        case (state)
            ST_IDLE: if (win_vld) state_nxt = ST_WAIT;
            ST_WAIT: if (i_bus_ready || tmo_hit) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : datapath
        if (!i_rst_n) begin
            last_winner   <= LAST_INIT;
            wait_cnt      <= '0;
            o_req_gnt     <= '0;
            o_req_ready   <= '0;
            o_req_rdata   <= '0;
            o_bus_rden    <= 1'b0;
            o_bus_wren    <= 1'b0;
            o_bus_addr    <= '0;
            o_bus_wdata   <= '0;
            o_bus_wstrb   <= '0;
            o_timeout_err <= 1'b0;
            o_err_id      <= '0;
        end else begin
            // Strobes and grant are single-cycle: they fall on the edge after issue.
            o_req_gnt  <= '0;
            o_bus_rden <= 1'b0;
            o_bus_wren <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        last_winner <= win_idx;
                        wait_cnt    <= '0;
                        o_bus_addr  <= sel_addr;
                        o_bus_wdata <= sel_wdata;
                        o_bus_wstrb <= sel_wstrb;
                        o_bus_wren  <= sel_wren;
                        // A requester raising both strobes is treated as a write.
                        o_bus_rden  <= sel_rden & ~sel_wren;
                        o_req_gnt   <= REQ_ONE << win_idx;
                    end
                end
                ST_WAIT: begin
                    // A real completion on the timeout edge wins over the forced one.
                    if (i_bus_ready) begin
                        o_req_ready <= REQ_ONE << last_winner;
                        o_req_rdata <= i_bus_rdata;
                    end else if (tmo_hit) begin
                        o_req_ready   <= REQ_ONE << last_winner;
                        o_req_rdata   <= '0;
                        o_timeout_err <= 1'b1;
                        o_err_id      <= last_winner;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    o_req_ready   <= '0;
                    o_timeout_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/peri_bus_arbiter.md
PERI_BUS_ARBITER -- requirements
Module: peri_bus_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing the peripheral bus, range 2..8.
REQ-002 Parameter: TIMEOUT, default 255, WAIT cycles without bus ready before forced completion, range 1..65535.
REQ-003 i_clk  input  1  clock; all state changes on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req_rden  input  NUM_REQ  per-requester read request, level, held until own o_req_ready.
REQ-006 i_req_wren  input  NUM_REQ  per-requester write request, level, held until own o_req_ready.
REQ-007 i_req_addr  input  NUM_REQ*32  per-requester address, slice i at [32*i+:32].
REQ-008 i_req_wdata  input  NUM_REQ*32  per-requester write data, slice i at [32*i+:32].
REQ-009 i_req_wstrb  input  NUM_REQ*4  per-requester byte strobes, slice i at [4*i+:4].
REQ-010 o_req_gnt  output  NUM_REQ  one-hot one-cycle pulse: request i accepted.
REQ-011 o_req_ready  output  NUM_REQ  one-hot one-cycle pulse: transaction i complete.
REQ-012 o_req_rdata  output  32  read data, valid while any o_req_ready bit is high.
REQ-013 o_bus_rden / o_bus_wren  output  1 each  single-cycle command strobes to the peripheral bus.
REQ-014 o_bus_addr / o_bus_wdata  output  32 each; o_bus_wstrb  output  4  command fields, held stable from issue until return to IDLE.
REQ-015 i_bus_ready  input  1  completion from the peripheral bus; i_bus_rdata  input  32  read data qualified by i_bus_ready.
REQ-016 o_timeout_err  output  1  one-cycle pulse on forced completion; o_err_id  output  3  index of timed-out requester, held until next timeout.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP; one outstanding transaction at most.
REQ-018 In IDLE, requester i is active if i_req_rden[i] or i_req_wren[i]; winner = first active index searching circularly from last_winner+1.
REQ-019 On the IDLE edge with a winner: latch winner index; register addr/wdata/wstrb; o_bus_wren<=wren[win]; o_bus_rden<=rden[win] & ~wren[win] (write wins if both set); o_req_gnt[win]<=1; last_winner<=win; clear timeout counter; go to WAIT.
REQ-020 Bus strobes and o_req_gnt SHALL be high exactly one cycle (first WAIT cycle) and deasserted on the following edge.
REQ-021 In WAIT with i_bus_ready=1: o_req_ready[win]<=1; o_req_rdata<=i_bus_rdata (also for writes); go to RESP.
REQ-022 In WAIT with i_bus_ready=0: counter increments; when counter==TIMEOUT-1 on that edge: o_req_ready[win]<=1, o_req_rdata<=0, o_timeout_err<=1, o_err_id<=win, go to RESP.
REQ-023 i_bus_ready high on the same edge as the timeout SHALL take priority; no error is flagged.
REQ-024 In RESP: clear o_req_ready, o_timeout_err; ignore all requests; go to IDLE unconditionally. Requesters drop requests in the cycle they see o_req_ready.
REQ-025 Issue-to-issue minimum spacing SHALL be 3 cycles (IDLE, WAIT>=1, RESP); bus latency L cycles gives L+2 total.
REQ-026 i_bus_ready in IDLE or RESP SHALL be ignored.
REQ-027 Counter width SHALL be 16 bits; no wrap occurs because TIMEOUT<=65535.

Reset
REQ-028 On i_rst_n low, state SHALL be IDLE, last_winner=NUM_REQ-1 (requester 0 highest priority first), counter=0, all outputs 0; an in-flight transaction is abandoned without o_req_ready.
REQ-029 Reset deassertion SHALL be synchronised by the integrating top; the block accepts requests on the first edge after release.

Verification
REQ-030 Single read: req1 rden, addr 0x0001_0004; bus ready 2 cycles after strobe with rdata 0xA5A5_0001 -> o_req_gnt=0b0010, one o_bus_rden pulse, o_req_ready=0b0010 with rdata 0xA5A5_0001.
REQ-031 Round-robin: all four request continuously, bus ready 1 cycle after each strobe -> grant order 0,1,2,3,0,1; no requester starved.
REQ-032 Timeout: TIMEOUT=8, req2 write, bus never ready -> o_req_ready[2] and o_timeout_err pulse together 8 cycles after gnt, o_req_rdata=0, o_err_id=2.
REQ-033 Ready on timeout edge: i_bus_ready asserted in the 8th WAIT cycle -> normal completion, o_timeout_err stays 0.
REQ-034 rden and wren both set by req0 -> only o_bus_wren pulses; stray i_bus_ready in IDLE -> no o_req_ready.
REQ-035 Reset asserted in WAIT -> all outputs 0 immediately; after release, req0 granted first.
